// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock-divider bank.
package clkdiv_pkg;

   typedef enum logic [1:0] {
      WAIT_PLL,
      ALIGN,
      COUNT,
      LOCKED
   } fsm_state_e;

   localparam int unsigned MIN_DIV    = 2;
   localparam int unsigned LOCK_CNT_W = 16;

   // Cycles clk_div stays high per period; odd divides are high-biased.
   function automatic int unsigned half_period(input int unsigned n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Divider-programming handshake: one write slot, ready/valid with error pulse.
interface clkdiv_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DIV_W  = 8
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              div_wr;
   logic [CH_W-1:0]   div_ch;
   logic [DIV_W-1:0]  div_val;
   logic              div_ready;
   logic              div_err;

   modport master (output div_wr, div_ch, div_val, input div_ready, div_err);
   modport slave  (input div_wr, div_ch, div_val, output div_ready, div_err);

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: wrap counter, registered divided clock and wrap enable.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int unsigned DIV_W   = 8,
   parameter int unsigned DEF_DIV = 16
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             run,
   input  logic             load_now,
   input  logic             load_req,
   input  logic [DIV_W-1:0] load_val,
   output logic             clk_div,
   output logic             clk_en,
   output logic             load_done
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             clk_div_q, clk_div_d;
   logic             clk_en_q, clk_en_d;
   logic [DIV_W:0]   half;
   logic             wrap;

   always_comb begin
      half      = (DIV_W+1)'(half_period(32'(div_q)));
      wrap      = (cnt_q == (div_q - DIV_W'(1)));
      cnt_d     = '0;
      if (run && !wrap) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      // While counting, a new divide only lands on the wrap so the running period finishes intact.
      load_done = load_req && (load_now || (run && wrap));
      div_d     = load_done ? load_val : div_q;
      clk_div_d = run && ({1'b0, cnt_q} < half);
      clk_en_d  = run && wrap;
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         div_q     <= DIV_W'(DEF_DIV);
         cnt_q     <= '0;
         clk_div_q <= 1'b0;
         clk_en_q  <= 1'b0;
      end else begin
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         clk_div_q <= clk_div_d;
         clk_en_q  <= clk_en_d;
      end
   end

   assign clk_div = clk_div_q;
   assign clk_en  = clk_en_q;

endmodule

// File: rtl/clkdiv_bank.sv
// Multi-channel clock divider bank: PLL-lock sync, align/lock FSM,
// single pending divider write slot and per-channel dividers.
module clkdiv_bank
   import clkdiv_pkg::*;
#(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned DEF_DIV     = 16,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              pll_lock,
   clkdiv_if.slave           div_bus,
   output logic [NUM_CH-1:0] clk_div,
   output logic [NUM_CH-1:0] clk_en,
   output logic              lock
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                  sync1_q, pll_s;
   fsm_state_e            state_q, state_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

   logic                  slot_full_q, slot_full_d;
   logic [CH_W-1:0]       slot_ch_q, slot_ch_d;
   logic [DIV_W-1:0]      slot_val_q, slot_val_d;
   logic                  err_q, err_d;

   logic                  run, load_now, illegal;
   logic [NUM_CH-1:0]     load_req, load_done;

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         pll_s   <= 1'b0;
      end else begin
         sync1_q <= pll_lock;
         pll_s   <= sync1_q;
      end
   end

   // Lock counter runs from ALIGN so LOCKED lands LOCK_CYCLES after the alignment cycle.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      unique case (state_q)
         WAIT_PLL: begin
            lock_cnt_d = '0;
            if (pll_s) state_d = ALIGN;
         end
         ALIGN: begin
            lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
            state_d    = COUNT;
         end
         COUNT: begin
            lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
            if (lock_cnt_q >= LOCK_CNT_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
         end
         LOCKED:  state_d = LOCKED;
         default: state_d = WAIT_PLL;
      endcase
      if (!pll_s) begin
         state_d    = WAIT_PLL;
         lock_cnt_d = '0;
      end
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_q    <= WAIT_PLL;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign run      = (state_q != WAIT_PLL);
   assign load_now = (state_q == WAIT_PLL) || (state_q == ALIGN);
   assign illegal  = (32'(div_bus.div_val) < MIN_DIV) || (32'(div_bus.div_ch) >= NUM_CH);

   always_comb begin
      slot_full_d = slot_full_q;
      slot_ch_d   = slot_ch_q;
      slot_val_d  = slot_val_q;
      err_d       = 1'b0;
      if (slot_full_q) begin
         if (|load_done) slot_full_d = 1'b0;
      end else if (div_bus.div_wr) begin
         if (illegal) begin
            err_d = 1'b1;
         end else begin
            slot_full_d = 1'b1;
            slot_ch_d   = div_bus.div_ch;
            slot_val_d  = div_bus.div_val;
         end
      end
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         slot_full_q <= 1'b0;
         slot_ch_q   <= '0;
         slot_val_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         slot_full_q <= slot_full_d;
         slot_ch_q   <= slot_ch_d;
         slot_val_q  <= slot_val_d;
         err_q       <= err_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load_req[i] = slot_full_q && (slot_ch_q == CH_W'(i));

      clkdiv_channel #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clkin     (clkin),
         .reset     (reset),
         .run       (run),
         .load_now  (load_now),
         .load_req  (load_req[i]),
         .load_val  (slot_val_q),
         .clk_div   (clk_div[i]),
         .clk_en    (clk_en[i]),
         .load_done (load_done[i])
      );
   end

   assign div_bus.div_ready = !slot_full_q;
   assign div_bus.div_err   = err_q;
   // Gated with the synchronised lock so lock drops one cycle ahead of the FSM.
   assign lock              = (state_q == LOCKED) && pll_s;

endmodule
